// File: rtl/timer_pkg.sv
// Shared types for the down-counter timer: FSM state encoding and default width.
package timer_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Load handshake, control and status bundle for down_counter_timer; master drives controls, slave returns status.
interface down_counter_timer_if #(parameter int WIDTH = timer_pkg::DEF_WIDTH);

  logic             abort;
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output abort, load_valid, load_value, en, auto_reload,
    input  load_ready, count, busy, done, tc
  );

  modport slave (
    input  abort, load_valid, load_value, en, auto_reload,
    output load_ready, count, busy, done, tc
  );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: load visible one edge after accept, tc one edge after terminal count.
// Loads are refused (load_ready=0) while RUN and are not queued; abort beats load.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  down_counter_timer_if.slave       bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;
  logic             w_load_rdy;
  logic             w_load_acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  assign w_load_acc = bus.load_valid & w_load_rdy;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
    end else if (w_load_acc) begin
      w_count_nxt  = bus.load_value;
      w_reload_nxt = bus.load_value;
      // A zero load is its own terminal count.
      if (bus.load_value == '0) begin
        w_state_nxt = DONE;
        w_tc_nxt    = 1'b1;
      end else begin
        w_state_nxt = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (bus.en) begin
            if (r_count == WIDTH'(1)) begin
              w_tc_nxt = 1'b1;
              if (bus.auto_reload) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = '0;
                w_state_nxt = DONE;
              end
            end else begin
              w_count_nxt = r_count - WIDTH'(1);
            end
          end
        end
        IDLE:    w_count_nxt = '0;
        DONE:    w_count_nxt = '0;
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_load_rdy     = (r_state != RUN);
    bus.load_ready = w_load_rdy;
    bus.busy       = (r_state == RUN);
    bus.done       = (r_state == DONE);
    bus.count      = r_count;
    bus.tc         = r_tc;
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: cycle-level reference model compared every cycle plus literal spot checks.
module tb_down_counter_timer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  down_counter_timer_if #(.WIDTH(W)) bus();

  down_counter_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = counting, 2 = finished.
  int m_mode   = 0;
  int m_count  = 0;
  int m_reload = 0;
  int m_tc     = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_count = 0; m_reload = 0; m_tc = 0;
    end else if (bus.abort) begin
      m_mode = 0; m_count = 0; m_tc = 0;
    end else if (bus.load_valid && m_mode != 1) begin
      m_reload = int'(bus.load_value);
      m_count  = m_reload;
      m_tc     = (m_reload == 0) ? 1 : 0;
      m_mode   = (m_reload == 0) ? 2 : 1;
    end else begin
      m_tc = 0;
      if (m_mode == 1 && bus.en) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (bus.auto_reload) m_count = m_reload;
          else begin m_count = 0; m_mode = 2; end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_count", int'(bus.count), m_count);
      chk("model_tc", int'(bus.tc), m_tc);
      chk("model_busy", int'(bus.busy), (m_mode == 1) ? 1 : 0);
      chk("model_done", int'(bus.done), (m_mode == 2) ? 1 : 0);
      chk("model_load_ready", int'(bus.load_ready), (m_mode != 1) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    bus.load_valid = 1'b1;
    bus.load_value = W'(v);
    step();
    bus.load_valid = 1'b0;
  endtask

  int exp_c[6]  = '{2, 1, 3, 2, 1, 3};
  int exp_tc[6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    bus.abort = 1'b0; bus.load_valid = 1'b1; bus.load_value = 4'd9;
    bus.en = 1'b1; bus.auto_reload = 1'b0;

    // Reset held two cycles with a pending load that must be ignored.
    step();
    cmp_on = 1'b1;
    step();
    chk("rst_count", int'(bus.count), 0);
    chk("rst_load_ready", int'(bus.load_ready), 1);
    chk("rst_tc", int'(bus.tc), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b1; bus.load_valid = 1'b0;
    step();
    chk("idle_count", int'(bus.count), 0);

    // One-shot from 5.
    load(5);
    chk("os_first", int'(bus.count), 5);
    chk("os_busy", int'(bus.busy), 1);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk("os_count", int'(bus.count), i);
      chk("os_tc_low", int'(bus.tc), 0);
    end
    step();
    chk("os_end_count", int'(bus.count), 0);
    chk("os_tc", int'(bus.tc), 1);
    chk("os_done", int'(bus.done), 1);
    step();
    chk("os_tc_drop", int'(bus.tc), 0);
    chk("os_hold", int'(bus.count), 0);

    // Auto-reload with period 3.
    bus.auto_reload = 1'b1;
    load(3);
    chk("ar_first", int'(bus.count), 3);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ar_count", int'(bus.count), exp_c[i]);
      chk("ar_tc", int'(bus.tc), exp_tc[i]);
      chk("ar_busy", int'(bus.busy), 1);
      chk("ar_done", int'(bus.done), 0);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0; bus.auto_reload = 1'b0;
    chk("ar_abort_count", int'(bus.count), 0);
    chk("ar_abort_busy", int'(bus.busy), 0);

    // Pause for three cycles with an ignored load of 7 in RUN.
    load(4);
    step(); step();
    chk("pz_at2", int'(bus.count), 2);
    bus.en = 1'b0; bus.load_valid = 1'b1; bus.load_value = 4'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pz_hold", int'(bus.count), 2);
      chk("pz_rdy", int'(bus.load_ready), 0);
      chk("pz_tc", int'(bus.tc), 0);
    end
    bus.en = 1'b1; bus.load_valid = 1'b0;
    step();
    chk("pz_resume", int'(bus.count), 1);
    step();
    chk("pz_tc_late", int'(bus.tc), 1);
    chk("pz_done", int'(bus.done), 1);

    // Zero load, then all-ones load.
    load(0);
    chk("z_tc", int'(bus.tc), 1);
    chk("z_done", int'(bus.done), 1);
    chk("z_count", int'(bus.count), 0);
    step();
    chk("z_tc_drop", int'(bus.tc), 0);
    load(15);
    chk("w_first", int'(bus.count), 15);
    for (int i = 14; i >= 1; i--) begin
      step();
      chk("w_count", int'(bus.count), i);
    end
    step();
    chk("w_end", int'(bus.count), 0);
    chk("w_tc", int'(bus.tc), 1);
    step();
    chk("w_nowrap", int'(bus.count), 0);

    // Abort together with a load mid-run.
    load(10);
    for (int i = 0; i < 4; i++) step();
    chk("ab_at6", int'(bus.count), 6);
    bus.abort = 1'b1; bus.load_valid = 1'b1; bus.load_value = 4'd3;
    step();
    bus.abort = 1'b0; bus.load_valid = 1'b0;
    chk("ab_count", int'(bus.count), 0);
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_done", int'(bus.done), 0);
    chk("ab_tc", int'(bus.tc), 0);
    step();
    chk("ab_stay", int'(bus.count), 0);

    // Reset together with a load mid-run.
    load(10);
    for (int i = 0; i < 4; i++) step();
    chk("rr_at6", int'(bus.count), 6);
    rst = 1'b0; bus.load_valid = 1'b1; bus.load_value = 4'd3;
    step();
    rst = 1'b1; bus.load_valid = 1'b0;
    chk("rr_count", int'(bus.count), 0);
    chk("rr_busy", int'(bus.busy), 0);
    chk("rr_tc", int'(bus.tc), 0);
    chk("rr_rdy", int'(bus.load_ready), 1);
    step();
    chk("rr_stay", int'(bus.count), 0);
    chk("rr_stay_done", int'(bus.done), 0);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
